// File: rtl/btn_pkg.sv
// Shared definitions for the push-button event queue: event codes,
// the default debounce length and the press-priority helpers.
package btn_pkg;

  typedef logic [1:0] btn_code_t;

  localparam btn_code_t BTN_UP    = 2'b00;
  localparam btn_code_t BTN_DOWN  = 2'b01;
  localparam btn_code_t BTN_LEFT  = 2'b10;
  localparam btn_code_t BTN_RIGHT = 2'b11;

  // 1 ms at 50 MHz
  localparam int unsigned BTN_DEBOUNCE_DEFAULT = 50000;

  // Press vector bit order is {right, left, down, up}; up wins.
  function automatic btn_code_t btn_pick(input logic [3:0] press);
    btn_code_t code;
    code = BTN_UP;
    if (press[0])      code = BTN_UP;
    else if (press[1]) code = BTN_DOWN;
    else if (press[2]) code = BTN_LEFT;
    else if (press[3]) code = BTN_RIGHT;
    return code;
  endfunction

  // More than one press in the same cycle means some are lost.
  function automatic logic btn_multi(input logic [3:0] press);
    return (press & (press - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, stable-run counter,
// accepted level and a one-cycle pulse on each accepted press.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
)
(
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned     CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Bring the raw asynchronous level into the clock domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive cycles that disagree with the accepted level; accept after a full run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Registered one-cycle pulse on a 0->1 change of the accepted level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/btn_event_queue.sv
// Four debounced buttons feeding a small press-event FIFO that the CPU
// pops one code at a time, with a sticky flag for lost events.
module btn_event_queue
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
  parameter int unsigned DEPTH           = 4
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_u,
  input  logic                   btn_d,
  input  logic                   btn_l,
  input  logic                   btn_r,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [1:0]             ev_code,
  output logic                   ev_valid,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   overflow
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [3:0]       w_btn_raw;
  logic [3:0]       w_press;

  btn_code_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  btn_code_t        r_head;
  logic             r_ovf;

  logic             w_pop;
  logic             w_push_req;
  logic             w_push;
  logic             w_drop_multi;
  logic             w_drop_full;
  btn_code_t        w_push_code;
  logic [PTR_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_cnt_after_pop;
  logic [CNT_W-1:0] w_cnt_next;
  btn_code_t        w_head_next;

  assign w_btn_raw = {btn_r, btn_l, btn_d, btn_u};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (w_btn_raw[g]),
        .o_press(w_press[g])
      );
    end
  endgenerate

  // Decide push/pop for this cycle and what the head register must show next.
  always_comb begin
    w_pop           = rd_en && (r_count != '0);
    w_push_req      = |w_press;
    w_push_code     = btn_pick(w_press);
    w_drop_multi    = btn_multi(w_press);
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    w_push          = w_push_req && ((r_count != FULL_CNT) || w_pop);
    w_drop_full     = w_push_req && !w_push;
    w_rd_next       = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_cnt_after_pop = w_pop ? r_count - CNT_W'(1) : r_count;
    w_cnt_next      = w_push ? w_cnt_after_pop + CNT_W'(1) : w_cnt_after_pop;
    // The new entry becomes head only when nothing older remains after the pop.
    if (w_cnt_next == '0)
      w_head_next = BTN_UP;
    else if (w_cnt_after_pop == '0)
      w_head_next = w_push_code;
    else
      w_head_next = r_mem[w_rd_next];
  end

  // Event storage; occupancy tracking makes stale entries harmless, so no reset.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_push_code;
  end

  // Pointers, occupancy and registered head; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= BTN_UP;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_count  <= w_cnt_next;
      r_head   <= w_head_next;
    end
  end

  // Sticky lost-event flag; a new loss beats a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_ovf <= 1'b0;
    else if (w_drop_multi || w_drop_full)
      r_ovf <= 1'b1;
    else if (clr_ovf)
      r_ovf <= 1'b0;
  end

  assign ev_code  = r_head;
  assign ev_valid = (r_count != '0);
  assign ev_count = r_count;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_btn_event_queue.sv
`timescale 1ns/1ps
module tb_btn_event_queue;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam logic [15:0] WMASK = 16'((1 << D) - 1);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic       rd_en = 1'b0, clr_ovf = 1'b0;
  logic [1:0] ev_code;
  logic       ev_valid;
  logic [2:0] ev_count;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btn_event_queue #(.DEBOUNCE_CYCLES(D), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_u   (btn_u),
    .btn_d   (btn_d),
    .btn_l   (btn_l),
    .btn_r   (btn_r),
    .rd_en   (rd_en),
    .clr_ovf (clr_ovf),
    .ev_code (ev_code),
    .ev_valid(ev_valid),
    .ev_count(ev_count),
    .overflow(overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a level is accepted once the synchronized stream has
  // disagreed with it for the last D samples; an accepted press lands in the
  // queue two edges later.
  bit          m_d1[4], m_d2[4], m_acc[4];
  logic [15:0] m_hist[4];
  int          m_since[4], m_due[4];
  int          m_cyc = 0;
  int          m_q[$];
  bit          m_ovf;
  logic [3:0]  m_raw;
  bit          m_pr[4];
  bit          m_pop, m_ovf_set, m_s2;
  int          m_npr, m_first;

  always @(posedge clk) begin
    m_raw = {btn_r, btn_l, btn_d, btn_u};
    if (!reset) begin
      for (int b = 0; b < 4; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_acc[b] = 0;
        m_hist[b] = '0; m_since[b] = 0; m_due[b] = -1;
      end
      m_q.delete();
      m_ovf = 0;
    end else begin
      for (int b = 0; b < 4; b++) m_pr[b] = (m_due[b] == m_cyc);
      for (int b = 0; b < 4; b++) begin
        m_s2 = m_d2[b];
        m_d2[b] = m_d1[b];
        m_d1[b] = m_raw[b];
        m_hist[b] = {m_hist[b][14:0], m_s2};
        m_since[b]++;
        if (m_since[b] >= D &&
            (m_hist[b] & WMASK) == (m_acc[b] ? 16'h0000 : WMASK)) begin
          m_acc[b] = ~m_acc[b];
          m_since[b] = 0;
          if (m_acc[b]) m_due[b] = m_cyc + 2;
        end
      end
      m_pop = rd_en && (m_q.size() > 0);
      if (m_pop) void'(m_q.pop_front());
      m_ovf_set = 0;
      m_npr = 0;
      m_first = -1;
      for (int b = 0; b < 4; b++) begin
        if (m_pr[b]) begin
          m_npr++;
          if (m_first < 0) m_first = b;
        end
      end
      if (m_npr > 0) begin
        if (m_npr > 1) m_ovf_set = 1;
        if (m_q.size() < DEPTH) m_q.push_back(m_first);
        else m_ovf_set = 1;
      end
      if (m_ovf_set) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
    m_cyc++;
    #1;
    chk("model_ev_valid", int'(ev_valid), (m_q.size() > 0) ? 1 : 0);
    chk("model_ev_count", int'(ev_count), m_q.size());
    chk("model_ev_code",  int'(ev_code),  (m_q.size() > 0) ? m_q[0] : 0);
    chk("model_overflow", int'(overflow), int'(m_ovf));
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_u = v;
      1: btn_d = v;
      2: btn_l = v;
      default: btn_r = v;
    endcase
  endtask

  task automatic press(input int b);
    @(negedge clk) set_btn(b, 1'b1);
    edges(8);
    @(negedge clk) set_btn(b, 1'b0);
    edges(8);
  endtask

  task automatic pop();
    @(negedge clk) rd_en = 1'b1;
    edges(1);
    @(negedge clk) rd_en = 1'b0;
  endtask

  int exp_codes[4];

  initial begin
    // reset state
    reset = 1'b0;
    edges(3);
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_count", int'(ev_count), 0);
    chk("rst_code",  int'(ev_code),  0);
    chk("rst_ovf",   int'(overflow), 0);
    @(negedge clk) reset = 1'b1;
    edges(2);

    // clean down step, latency D+3
    @(negedge clk) btn_d = 1'b1;
    edges(7);
    chk("step_e6_valid", int'(ev_valid), 0);
    edges(1);
    chk("step_e7_valid", int'(ev_valid), 1);
    chk("step_e7_code",  int'(ev_code),  1);
    @(negedge clk) begin btn_d = 1'b0; rd_en = 1'b1; end
    edges(1);
    chk("step_pop_valid", int'(ev_valid), 0);
    chk("step_pop_count", int'(ev_count), 0);
    @(negedge clk) rd_en = 1'b0;
    edges(1);
    // read while empty
    pop();
    chk("empty_rd_count", int'(ev_count), 0);
    chk("empty_rd_ovf",   int'(overflow), 0);
    edges(8);

    // bounce then hold, then a short glitch
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) btn_u = (i % 2 == 0);
    end
    @(negedge clk) btn_u = 1'b1;
    edges(12);
    chk("bounce_count", int'(ev_count), 1);
    chk("bounce_code",  int'(ev_code),  0);
    @(negedge clk) btn_u = 1'b0;
    edges(10);
    pop();
    chk("bounce_drain", int'(ev_count), 0);
    @(negedge clk) btn_u = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) btn_u = 1'b0;
    edges(12);
    chk("glitch_count", int'(ev_count), 0);

    // five presses, no reads: last one lost
    press(0); press(2); press(3); press(1); press(0);
    chk("full_count", int'(ev_count), 4);
    chk("full_ovf",   int'(overflow), 1);
    exp_codes = '{0, 2, 3, 1};
    for (int i = 0; i < 4; i++) begin
      chk("fifo_order", int'(ev_code), exp_codes[i]);
      pop();
    end
    chk("fifo_drained", int'(ev_count), 0);
    @(negedge clk) clr_ovf = 1'b1;
    edges(1);
    chk("clr_ovf_a", int'(overflow), 0);
    @(negedge clk) clr_ovf = 1'b0;

    // full queue with push and pop on the same edge
    press(0); press(1); press(2); press(3);
    chk("fill_count", int'(ev_count), 4);
    chk("fill_ovf",   int'(overflow), 0);
    @(negedge clk) btn_u = 1'b1;
    edges(7);
    @(negedge clk) rd_en = 1'b1;
    edges(1);
    chk("pp_count", int'(ev_count), 4);
    chk("pp_ovf",   int'(overflow), 0);
    chk("pp_head",  int'(ev_code),  1);
    @(negedge clk) begin rd_en = 1'b0; btn_u = 1'b0; end
    edges(8);
    exp_codes = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", int'(ev_code), exp_codes[i]);
      pop();
    end
    chk("pp_drained", int'(ev_count), 0);

    // left and right accepted together
    @(negedge clk) begin btn_l = 1'b1; btn_r = 1'b1; end
    edges(8);
    chk("lr_count", int'(ev_count), 1);
    chk("lr_code",  int'(ev_code),  2);
    chk("lr_ovf",   int'(overflow), 1);
    @(negedge clk) begin clr_ovf = 1'b1; btn_l = 1'b0; btn_r = 1'b0; end
    edges(1);
    chk("lr_clr", int'(overflow), 0);
    @(negedge clk) clr_ovf = 1'b0;
    edges(8);
    pop();
    chk("lr_drained", int'(ev_count), 0);

    // reset with queued events and a held button mid-debounce
    press(0); press(1); press(2);
    chk("pre_rst_count", int'(ev_count), 3);
    @(negedge clk) btn_r = 1'b1;
    edges(3);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("arst_valid", int'(ev_valid), 0);
    chk("arst_count", int'(ev_count), 0);
    chk("arst_code",  int'(ev_code),  0);
    chk("arst_ovf",   int'(overflow), 0);
    edges(2);
    @(negedge clk) reset = 1'b1;
    edges(7);
    chk("held_e6_valid", int'(ev_valid), 0);
    edges(1);
    chk("held_e7_valid", int'(ev_valid), 1);
    chk("held_e7_code",  int'(ev_code),  3);
    chk("held_e7_count", int'(ev_count), 1);
    edges(10);
    chk("held_once", int'(ev_count), 1);
    @(negedge clk) btn_r = 1'b0;
    edges(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
